inv_mixcolumns_iter: RTL and testbench
======================================

Name: inv_mixcolumns_iter

Overview:
Iterative AES InvMixColumns unit for the decrypt datapath: the inverse of the encrypt-side MixColumns transform.
- Accepts one 128-bit state per valid/ready handshake.
- Transforms COLS_PER_CYCLE columns per clock over GF(2^8) and presents the result with a valid/ready output handshake.
- Sits between InvShiftRows/InvSubBytes/AddRoundKey in the decrypt round loop and trades area (shared multiplier columns) for latency.

Parameters:
- GF_POLY, 8'h1B: low byte of the reduction polynomial x^8+x^4+x^3+x+1, used by xtime.
- COLS_PER_CYCLE, 1: columns transformed per clock. Legal values are 1, 2, 4; any other value is an elaboration error.

Ports:
- clk, input, 1: single clock, rising-edge.
- rst_n, input, 1: asynchronous active-low reset.
- in_valid, input, 1: in_data is valid.
- in_ready, output, 1: block can accept a state.
- in_data, input, 128: state. Column c = in_data[127-32c -: 32]; row 0 is the MSB byte of each column.
- out_valid, output, 1: out_data is valid.
- out_ready, input, 1: downstream accepts out_data.
- out_data, output, 128: transformed state, same byte layout as in_data.
- busy, output, 1: high in COMPUTE or DONE.

Behaviour:
- Clock and reset: one clock (clk); reset rst_n is asynchronous, active-low.
- Reset values (asynchronous, at rst_n low): state=IDLE, in_ready=1, out_valid=0, busy=0, out_data=128'h0. Column counter and internal state register are also cleared.
- Per-column math: with column bytes a0..a3,
  - r0 = 0e·a0 ^ 0b·a1 ^ 0d·a2 ^ 09·a3
  - r1 = 09·a0 ^ 0e·a1 ^ 0b·a2 ^ 0d·a3
  - r2 = 0d·a0 ^ 09·a1 ^ 0e·a2 ^ 0b·a3
  - r3 = 0b·a0 ^ 0d·a1 ^ 09·a2 ^ 0e·a3
- Multiplier construction:
  - Multiplies are built from xtime(x) = {x[6:0],1'b0} ^ ({8{x[7]}} & GF_POLY).
  - 09=x8^x, 0b=x8^x2^x, 0d=x8^x4^x, 0e=x8^x4^x2, where x2/x4/x8 are successive xtimes.
  - All results are 8 bits; no carries.
- FSM states IDLE, COMPUTE, DONE:
  - IDLE: in_ready=1. On in_valid&in_ready, register in_data into the work register, clear col counter to 0, go to COMPUTE.
  - COMPUTE: in_ready=0. Each clock, transform columns col..col+COLS_PER_CYCLE-1 in place, then col += COLS_PER_CYCLE. After the edge that processes column 3, load out_data from the work register and go to DONE.
  - DONE: out_valid=1 and out_data is held stable. On out_ready, clear out_valid and go to IDLE. While out_ready=0, hold indefinitely; in_valid is ignored.
- Latency: out_valid rises 4/COLS_PER_CYCLE clocks after the input-accept edge, i.e. 4 for the default.
  - Minimum initiation interval is 4/COLS_PER_CYCLE + 2 clocks (accept, compute, DONE handshake, IDLE).
  - in_ready is never high while busy=1.
- Column order is fixed: column 0 (MSB) first.
- out_data changes only on the load edge into DONE. It keeps its last value in IDLE, so it does not glitch between results.
- in_data is sampled only on the accept edge; later changes are ignored.
- Asynchronous reset mid-COMPUTE or mid-DONE aborts immediately. Outputs take reset values; no partial result is ever presented.
- out_ready asserted outside DONE has no effect.

Test Plan:
- FIPS-197 columns: in_data=128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6 -> out_data=128'hdb135345_f20a225c_01010101_c6c6c6c6. Check out_valid exactly 4 clocks after accept (COLS_PER_CYCLE=1) and 1 clock after accept (COLS_PER_CYCLE=4).
- Second vector: in_data=128'hd5d5d7d6_4d7ebdf8_00000000_ffffffff -> out_data=128'hd4d4d4d5_2d26314c_00000000_ffffffff.
- Backpressure: hold out_ready=0 for 10 clocks in DONE while toggling in_valid and in_data. Require:
  - out_valid stays 1 and out_data is stable;
  - in_ready stays 0;
  - the input is accepted only after the out_ready handshake.
- Back-to-back: drive in_valid continuously with 3 states and out_ready=1. Require 3 correct outputs in order, at a 6-clock interval (default).
- Reset mid-operation: assert rst_n=0 two clocks after accept. Require out_valid=0, out_data=0, in_ready=1 asynchronously. After release, the next vector completes correctly.
- Round-trip: 1000 random states passed through a forward-MixColumns model, then this block. Output must equal the original state for all COLS_PER_CYCLE values.

Source files
------------

// File: rtl/inv_mixcolumns_iter.sv
// Iterative AES InvMixColumns: accepts one 128-bit state, transforms
// COLS_PER_CYCLE columns per clock on shared GF(2^8) lanes, then holds the result.
module inv_mixcolumns_iter #(
  parameter logic [7:0] GF_POLY        = 8'h1B,
  parameter int         COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;

  state_t       state, state_next;
  logic [127:0] work, work_next;
  logic [1:0]   col;
  logic         last_col;
  logic [31:0]  cols     [4];
  logic [31:0]  lane_in  [COLS_PER_CYCLE];
  logic [31:0]  lane_out [COLS_PER_CYCLE];

  generate
    if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cfg
      $error("inv_mixcolumns_iter: COLS_PER_CYCLE must be 1, 2 or 4");
    end
  endgenerate

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ ({8{x[7]}} & GF_POLY);
  endfunction

  function automatic logic [31:0] inv_col(input logic [31:0] a);
    logic [7:0] x1 [4];
    logic [7:0] x2 [4];
    logic [7:0] x4 [4];
    logic [7:0] x8 [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    for (int i = 0; i < 4; i++) begin
      x1[i] = a[31-8*i -: 8];
      x2[i] = xtime(x1[i]);
      x4[i] = xtime(x2[i]);
      x8[i] = xtime(x4[i]);
      m9[i] = x8[i] ^ x1[i];
      mb[i] = x8[i] ^ x2[i] ^ x1[i];
      md[i] = x8[i] ^ x4[i] ^ x1[i];
      me[i] = x8[i] ^ x4[i] ^ x2[i];
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  // Shared lanes pick up the block of columns starting at col.
  for (genvar gi = 0; gi < COLS_PER_CYCLE; gi++) begin : g_lane
    assign lane_in[gi]  = cols[col + 2'(gi)];
    assign lane_out[gi] = inv_col(lane_in[gi]);
  end

  // Each column is overwritten only when its block is the one being processed.
  for (genvar gi = 0; gi < 4; gi++) begin : g_col
    localparam int         LANE = gi % COLS_PER_CYCLE;
    localparam logic [1:0] BASE = 2'(gi - LANE);
    assign cols[gi] = work[127-32*gi -: 32];
    assign work_next[127-32*gi -: 32] =
      (state == COMPUTE && col == BASE) ? lane_out[LANE] : cols[gi];
  end

  assign last_col  = (col == 2'(4 - COLS_PER_CYCLE));
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid)  state_next = COMPUTE;
      COMPUTE: if (last_col)  state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default:                state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work     <= '0;
      col      <= '0;
      out_data <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          work <= in_data;
          col  <= '0;
        end
        COMPUTE: begin
          work <= work_next;
          col  <= col + 2'(COLS_PER_CYCLE);
          if (last_col) out_data <= work_next;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_inv_mixcolumns_iter.sv
// Bench for inv_mixcolumns_iter: three instances (1, 2, 4 columns per clock)
// checked against a matrix-based GF(2^8) reference model.
module tb_inv_mixcolumns_iter;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [2:0]   in_valid, in_ready, out_valid, out_ready, busy;
  logic [127:0] in_data  [3];
  logic [127:0] out_data [3];
  int           tests = 0;
  int           fails = 0;
  int           exp_lat [3] = '{4, 2, 1};

  always #5 clk = ~clk;

  inv_mixcolumns_iter #(.COLS_PER_CYCLE(1)) dut_c1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_data(in_data[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_data(out_data[0]), .busy(busy[0]));
  inv_mixcolumns_iter #(.COLS_PER_CYCLE(2)) dut_c2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_data(in_data[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_data(out_data[1]), .busy(busy[1]));
  inv_mixcolumns_iter #(.COLS_PER_CYCLE(4)) dut_c4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .in_data(in_data[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
    .out_data(out_data[2]), .busy(busy[2]));

  // Carry-less product followed by reduction modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [14:0] prod;
    logic [14:0] poly;
    prod = '0;
    poly = 15'h11B;
    for (int i = 0; i < 8; i++)
      if (b[i]) prod = prod ^ (15'(a) << i);
    for (int i = 14; i >= 8; i--)
      if (prod[i]) prod = prod ^ (poly << (i - 8));
    return prod[7:0];
  endfunction

  // Circulant matrix product per column; base holds the first matrix row.
  function automatic logic [127:0] mix(input logic [127:0] s, input logic [31:0] base);
    logic [127:0] r;
    logic [7:0]   a [4];
    logic [7:0]   acc;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int row = 0; row < 4; row++) a[row] = s[127-32*c-8*row -: 8];
      for (int row = 0; row < 4; row++) begin
        acc = '0;
        for (int k = 0; k < 4; k++) acc = acc ^ gmul(base[31-8*((k-row)&3) -: 8], a[k]);
        r[127-32*c-8*row -: 8] = acc;
      end
    end
    return r;
  endfunction

  function automatic logic [127:0] inv_mix(input logic [127:0] s);
    return mix(s, 32'h0e0b0d09);
  endfunction

  function automatic logic [127:0] fwd_mix(input logic [127:0] s);
    return mix(s, 32'h02030101);
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full transaction on instance d; lat counts clocks from accept to out_valid.
  task automatic run_one(input int d, input logic [127:0] x,
                         output logic [127:0] y, output int lat);
    int guard;
    guard = 0;
    while (!in_ready[d] && guard < 50) begin tick(); guard++; end
    if (!in_ready[d]) begin
      tests++; fails++;
      $display("FAIL accept_timeout dut%0d in_ready=%b required 1", d, in_ready[d]);
    end
    in_valid[d] = 1'b1;
    in_data[d]  = x;
    tick();
    in_valid[d] = 1'b0;
    in_data[d]  = rand128();
    lat = 0;
    while (!out_valid[d] && lat < 50) begin tick(); lat++; end
    y = out_data[d];
    out_ready[d] = 1'b1;
    tick();
    out_ready[d] = 1'b0;
    $display("[TB] dut%0d in=%h out=%h latency=%0d", d, x, y, lat);
  endtask

  task automatic test_reset();
    for (int d = 0; d < 3; d++) begin
      tests++;
      if (in_ready[d] !== 1'b1 || out_valid[d] !== 1'b0 || busy[d] !== 1'b0 ||
          out_data[d] !== 128'h0) begin
        fails++;
        $display("FAIL reset_state dut%0d in_ready=%b out_valid=%b busy=%b out_data=%h required 1/0/0/0",
                 d, in_ready[d], out_valid[d], busy[d], out_data[d]);
      end
    end
  endtask

  task automatic test_fips();
    logic [127:0] x, e, y;
    int lat;
    x = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
    e = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
    for (int d = 0; d < 3; d++) begin
      run_one(d, x, y, lat);
      tests++;
      if (y !== e) begin
        fails++;
        $display("FAIL fips_data dut%0d got=%h required=%h", d, y, e);
      end
      tests++;
      if (lat !== exp_lat[d]) begin
        fails++;
        $display("FAIL fips_latency dut%0d got=%0d required=%0d", d, lat, exp_lat[d]);
      end
    end
  endtask

  task automatic test_vector2();
    logic [127:0] x, e, y;
    int lat;
    x = 128'hd5d5d7d6_4d7ebdf8_00000000_ffffffff;
    e = 128'hd4d4d4d5_2d26314c_00000000_ffffffff;
    for (int d = 0; d < 3; d++) begin
      run_one(d, x, y, lat);
      tests++;
      if (y !== e) begin
        fails++;
        $display("FAIL vector2 dut%0d got=%h required=%h", d, y, e);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [127:0] x, e, z;
    int lat;
    x = rand128();
    e = inv_mix(x);
    in_valid[0] = 1'b1;
    in_data[0]  = x;
    tick();
    in_valid[0] = 1'b0;
    lat = 0;
    while (!out_valid[0] && lat < 50) begin tick(); lat++; end
    for (int k = 0; k < 10; k++) begin
      in_valid[0] = ~in_valid[0];
      in_data[0]  = rand128();
      tick();
      tests++;
      if (out_valid[0] !== 1'b1 || out_data[0] !== e || in_ready[0] !== 1'b0) begin
        fails++;
        $display("FAIL backpressure_hold cycle%0d out_valid=%b in_ready=%b out_data=%h required 1/0/%h",
                 k, out_valid[0], in_ready[0], out_data[0], e);
      end
    end
    z = rand128();
    in_valid[0]  = 1'b1;
    in_data[0]   = z;
    out_ready[0] = 1'b1;
    tick();
    out_ready[0] = 1'b0;
    tests++;
    if (in_ready[0] !== 1'b1 || out_valid[0] !== 1'b0) begin
      fails++;
      $display("FAIL backpressure_release in_ready=%b out_valid=%b required 1/0",
               in_ready[0], out_valid[0]);
    end
    tick();
    in_valid[0] = 1'b0;
    tests++;
    if (busy[0] !== 1'b1) begin
      fails++;
      $display("FAIL backpressure_accept busy=%b required 1", busy[0]);
    end
    lat = 0;
    while (!out_valid[0] && lat < 50) begin tick(); lat++; end
    tests++;
    if (out_data[0] !== inv_mix(z)) begin
      fails++;
      $display("FAIL backpressure_next got=%h required=%h", out_data[0], inv_mix(z));
    end
    $display("[TB] backpressure in=%h out=%h", z, out_data[0]);
    out_ready[0] = 1'b1;
    tick();
    out_ready[0] = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [127:0] v [3];
    logic [127:0] got_d [3];
    int got_c [3];
    int sent, got;
    for (int i = 0; i < 3; i++) v[i] = rand128();
    sent = 0;
    got  = 0;
    in_valid[0]  = 1'b1;
    in_data[0]   = v[0];
    out_ready[0] = 1'b1;
    for (int cyc = 0; cyc < 80 && got < 3; cyc++) begin
      if (out_valid[0]) begin
        got_d[got] = out_data[0];
        got_c[got] = cyc;
        $display("[TB] back_to_back out%0d=%h cycle=%0d", got, out_data[0], cyc);
        got++;
      end
      if (in_ready[0]) begin
        if (sent < 3) begin in_data[0] = v[sent]; sent++; end
        else in_valid[0] = 1'b0;
      end
      tick();
    end
    in_valid[0]  = 1'b0;
    out_ready[0] = 1'b0;
    tests++;
    if (got !== 3) begin
      fails++;
      $display("FAIL b2b_count got=%0d required=3", got);
    end
    for (int i = 0; i < got; i++) begin
      tests++;
      if (got_d[i] !== inv_mix(v[i])) begin
        fails++;
        $display("FAIL b2b_data idx%0d got=%h required=%h", i, got_d[i], inv_mix(v[i]));
      end
    end
    for (int i = 1; i < got; i++) begin
      tests++;
      if (got_c[i] - got_c[i-1] !== 6) begin
        fails++;
        $display("FAIL b2b_interval idx%0d got=%0d required=6", i, got_c[i] - got_c[i-1]);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [127:0] x, y;
    int lat;
    x = rand128();
    in_valid[0] = 1'b1;
    in_data[0]  = x;
    tick();
    in_valid[0] = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if (out_valid[0] !== 1'b0 || out_data[0] !== 128'h0 || in_ready[0] !== 1'b1 ||
        busy[0] !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid out_valid=%b out_data=%h in_ready=%b busy=%b required 0/0/1/0",
               out_valid[0], out_data[0], in_ready[0], busy[0]);
    end
    #3;
    rst_n = 1'b1;
    tick();
    x = rand128();
    run_one(0, x, y, lat);
    tests++;
    if (y !== inv_mix(x) || lat !== 4) begin
      fails++;
      $display("FAIL reset_recover got=%h lat=%0d required=%h lat=4", y, lat, inv_mix(x));
    end
  endtask

  task automatic test_round_trip();
    logic [127:0] s, y;
    int lat;
    for (int i = 0; i < 1000; i++) begin
      s = rand128();
      for (int d = 0; d < 3; d++) begin
        run_one(d, fwd_mix(s), y, lat);
        tests++;
        if (y !== s || lat !== exp_lat[d]) begin
          fails++;
          $display("FAIL round_trip dut%0d iter%0d got=%h lat=%0d required=%h lat=%0d",
                   d, i, y, lat, s, exp_lat[d]);
        end
      end
    end
  endtask

  initial begin
    in_valid  = '0;
    out_ready = '0;
    for (int d = 0; d < 3; d++) in_data[d] = '0;
    #3;
    test_reset();
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    tick();
    test_reset();
    test_fips();
    test_vector2();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_round_trip();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
